// File: rtl/lcd_hd44780_responder.sv
// LCD-side responder for a 4-bit HD44780 bus.
// Watches the host's RS/E/DB lines, assembles nibbles into bytes, executes
// the instruction set against a 32-character DDRAM mirror and reproduces the
// controller's busy timing so the host sees a realistic panel.
module lcd_hd44780_responder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 76000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [3:0] lcd_db,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       disp_on,
  output logic       four_bit_mode,
  output logic [4:0] cursor_addr,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       proto_err
);

  // The busy counter must hold the larger of the two busy periods.
  localparam int CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Counter loads are one less than the period because the BUSY state is
  // also occupied during the cycle in which the counter reads zero.
  localparam logic [CW-1:0] LOAD_SHORT = CW'((BUSY_SHORT > 0) ? BUSY_SHORT - 1 : 0);
  localparam logic [CW-1:0] LOAD_LONG  = CW'((BUSY_LONG > 0) ? BUSY_LONG - 1 : 0);

  // After a clear, the 32-cycle fill already counts toward the long busy
  // period, so only the remainder is spent in BUSY.
  localparam logic [CW-1:0] LOAD_TAIL  = CW'((BUSY_LONG > 32) ? BUSY_LONG - 33 : 0);
  localparam bit            HAS_TAIL   = (BUSY_LONG > 32);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [4:0]      fill_idx;
  logic            fill_long;
  logic            phase;
  logic [3:0]      hi_nib;
  logic            inc;

  // Synchronizer stages; the third stage remembers the previous value so a
  // falling edge of E can be seen together with the RS/DB that went with it.
  logic            e_s1, e_s2, e_s3;
  logic            rs_s1, rs_s2, rs_s3;
  logic [3:0]      db_s1, db_s2, db_s3;
  logic            strobe;

  logic            stb_q;
  logic            stb_rs;
  logic [3:0]      stb_db;

  logic            accept;
  logic            ignored;
  logic            hi_store;
  logic            exec_go;
  logic [7:0]      exec_byte;
  logic [4:0]      ac_up;
  logic [4:0]      ac_dn;

  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [7:0]      wr_data;
  logic [7:0]      mem [32];

  // Bring the asynchronous host lines into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_s1  <= 1'b0;
      e_s2  <= 1'b0;
      e_s3  <= 1'b0;
      rs_s1 <= 1'b0;
      rs_s2 <= 1'b0;
      rs_s3 <= 1'b0;
      db_s1 <= 4'h0;
      db_s2 <= 4'h0;
      db_s3 <= 4'h0;
    end else begin
      e_s1  <= lcd_e;
      e_s2  <= e_s1;
      e_s3  <= e_s2;
      rs_s1 <= lcd_rs;
      rs_s2 <= rs_s1;
      rs_s3 <= rs_s2;
      db_s1 <= lcd_db;
      db_s2 <= db_s1;
      db_s3 <= db_s2;
    end
  end

  assign strobe = e_s3 & ~e_s2;

  // Register the strobe with the RS/DB seen while E was still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_q  <= 1'b0;
      stb_rs <= 1'b0;
      stb_db <= 4'h0;
    end else begin
      stb_q <= strobe;
      if (strobe) begin
        stb_rs <= rs_s3;
        stb_db <= db_s3;
      end
    end
  end

  // Classify the pending strobe and form the byte it would execute.
  always_comb begin
    accept    = stb_q && !busy && (state == S_IDLE);
    ignored   = stb_q && !accept;
    hi_store  = accept && four_bit_mode && !phase;
    exec_go   = accept && (!four_bit_mode || phase);
    exec_byte = four_bit_mode ? {hi_nib, stb_db} : {stb_db, 4'h0};
    ac_up     = cursor_addr + 5'd1;
    ac_dn     = cursor_addr - 5'd1;
  end

  // Main controller: fill, idle, busy countdown and instruction execution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FILL;
      cnt           <= '0;
      fill_idx      <= 5'd0;
      fill_long     <= 1'b0;
      phase         <= 1'b0;
      hi_nib        <= 4'h0;
      inc           <= 1'b1;
      cursor_addr   <= 5'd0;
      disp_on       <= 1'b0;
      four_bit_mode <= 1'b0;
      busy          <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_rs        <= 1'b0;
      cmd_byte      <= 8'h00;
      proto_err     <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= 5'd0;
      wr_data       <= 8'h00;
    end else begin
      cmd_valid <= 1'b0;
      proto_err <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= (state != S_IDLE);

      case (state)
        S_FILL: begin
          wr_en    <= 1'b1;
          wr_addr  <= fill_idx;
          wr_data  <= 8'h20;
          fill_idx <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) begin
            fill_long <= 1'b0;
            if (fill_long && HAS_TAIL) begin
              state <= S_BUSY;
              cnt   <= LOAD_TAIL;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_IDLE: begin
        end
        default: state <= S_IDLE;
      endcase

      if (ignored) begin
        proto_err <= 1'b1;
      end

      if (hi_store) begin
        hi_nib <= stb_db;
        phase  <= 1'b1;
      end

      if (exec_go) begin
        // Every executed byte leaves the next strobe expecting a high
        // nibble, which also covers the phase reset on an interface change.
        phase     <= 1'b0;
        cmd_valid <= 1'b1;
        cmd_rs    <= stb_rs;
        cmd_byte  <= exec_byte;
        state     <= S_BUSY;
        cnt       <= LOAD_SHORT;

        if (stb_rs) begin
          wr_en       <= 1'b1;
          wr_addr     <= cursor_addr;
          wr_data     <= exec_byte;
          cursor_addr <= inc ? ac_up : ac_dn;
        end else if (exec_byte[7]) begin
          // Line 1 is 0x00-0x0F, line 2 is 0x40-0x4F; nothing else exists.
          if (exec_byte[6:4] == 3'b000) begin
            cursor_addr <= {1'b0, exec_byte[3:0]};
          end else if (exec_byte[6:4] == 3'b100) begin
            cursor_addr <= {1'b1, exec_byte[3:0]};
          end else begin
            proto_err <= 1'b1;
          end
        end else if (exec_byte[6]) begin
          cmd_rs <= 1'b0;
        end else if (exec_byte[5]) begin
          four_bit_mode <= ~exec_byte[4];
        end else if (exec_byte[4]) begin
          if (!exec_byte[3]) begin
            cursor_addr <= exec_byte[2] ? ac_up : ac_dn;
          end
        end else if (exec_byte[3]) begin
          disp_on <= exec_byte[2];
        end else if (exec_byte[2]) begin
          inc <= exec_byte[1];
        end else if (exec_byte[1]) begin
          cursor_addr <= 5'd0;
          cnt         <= LOAD_LONG;
        end else if (exec_byte[0]) begin
          state       <= S_FILL;
          fill_idx    <= 5'd0;
          fill_long   <= 1'b1;
          cursor_addr <= 5'd0;
          inc         <= 1'b1;
        end else begin
          proto_err <= 1'b1;
        end
      end
    end
  end

  // DDRAM mirror storage; written one cycle after the controller decides.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port for external consumers of the mirror.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
